pipeline_hazard_controller: RTL and testbench

Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Keeps an internal shadow of the register-use fields of in-flight instructions.
- From that shadow it drives the PC and IF/ID enables, the IF/ID and ID/EX flush/bubble controls, and the EX-stage forwarding selects.
- Counts stall and flush cycles for performance visibility.
- Sits beside the pipeline registers. It is the only source of their enable and flush controls.

---
 rtl/pipeline_hazard_controller.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use stalls,
// branch/jump flushes, EX forwarding selects, ID bypass and stall/flush statistics.
module pipeline_hazard_controller #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_jump,
    input  logic             ex_branch_taken,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             id_bypass_a,
    output logic             id_bypass_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, next_state;

    logic [REG_W-1:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic             ex_rw, ex_mr, mem_rw, wb_rw;
    logic             luh;

    // Register $0 is hard-wired, so it never matches as a producer.
    function automatic logic [1:0] fwd_select(
        input logic [REG_W-1:0] src,
        input logic             m_rw,
        input logic [REG_W-1:0] m_dest,
        input logic             w_rw,
        input logic [REG_W-1:0] w_dest
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_rw && (m_dest != '0) && (m_dest == src))
            sel = 2'b10;
        else if (w_rw && (w_dest != '0) && (w_dest == src))
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        luh = id_valid && ex_mr && ex_rw && (ex_dest != '0) &&
              ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)));
    end

    // NOTE: every output gets its default before the case, so no path can infer a latch.
    always_comb begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        next_state   = RUN;
        // While reset is asserted the controls are forced to free-running values.
        if (reset) begin
            case (state)
                RUN, LSTALL: begin
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        next_state   = FLUSH;
                    end else if ((state == RUN) && luh) begin
                        pc_enable    = 1'b0;
                        if_id_enable = 1'b0;
                        id_ex_bubble = 1'b1;
                        next_state   = LSTALL;
                    end else if (id_jump && id_valid) begin
                        if_id_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fwd_a_sel   = fwd_select(ex_rs, mem_rw, mem_dest, wb_rw, wb_dest);
        fwd_b_sel   = fwd_select(ex_rt, mem_rw, mem_dest, wb_rw, wb_dest);
        id_bypass_a = wb_rw && (wb_dest != '0) && (wb_dest == id_rs);
        id_bypass_b = wb_rw && (wb_dest != '0) && (wb_dest == id_rt);
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_dest      <= '0;
            ex_rw        <= 1'b0;
            ex_mr        <= 1'b0;
            mem_dest     <= '0;
            mem_rw       <= 1'b0;
            wb_dest      <= '0;
            wb_rw        <= 1'b0;
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            state <= next_state;
            if (id_ex_bubble || !id_valid) begin
                ex_rs   <= '0;
                ex_rt   <= '0;
                ex_dest <= '0;
                ex_rw   <= 1'b0;
                ex_mr   <= 1'b0;
            end else begin
                ex_rs   <= id_rs;
                ex_rt   <= id_rt;
                ex_dest <= id_dest;
                ex_rw   <= id_reg_write;
                ex_mr   <= id_mem_read;
            end
            mem_dest <= ex_dest;
            mem_rw   <= ex_rw;
            wb_dest  <= mem_dest;
            wb_rw    <= mem_rw;
            if (!pc_enable && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + CNT_ONE;
            if (if_id_flush && (flush_cycles != CNT_MAX))
                flush_cycles <= flush_cycles + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed vector table, reset/saturation sequences, and
// randomized stimulus against a pipeline-of-instructions reference model.
module tb_pipeline_hazard_controller;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 16;
    localparam int SMALL_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_jump;
    logic             ex_branch_taken;
    logic [REG_W-1:0] id_rs, id_rt, id_dest;

    logic             pc_enable, if_id_enable, if_id_flush, id_ex_bubble, id_bypass_a, id_bypass_b;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;

    logic               s_pc_enable, s_if_id_enable, s_if_id_flush, s_id_ex_bubble, s_id_bypass_a, s_id_bypass_b;
    logic [1:0]         s_fwd_a_sel, s_fwd_b_sel;
    logic [SMALL_W-1:0] s_stall_cycles, s_flush_cycles;

    pipeline_hazard_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    pipeline_hazard_controller #(.REG_W(REG_W), .CNT_W(SMALL_W)) dut_small (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .pc_enable(s_pc_enable), .if_id_enable(s_if_id_enable),
        .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble), .fwd_a_sel(s_fwd_a_sel),
        .fwd_b_sel(s_fwd_b_sel), .id_bypass_a(s_id_bypass_a), .id_bypass_b(s_id_bypass_b),
        .stall_cycles(s_stall_cycles), .flush_cycles(s_flush_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             valid;
        logic [REG_W-1:0] rs, rt;
        logic             urs, urt;
        logic [REG_W-1:0] dest;
        logic             rw, mr, jump, br;
    } in_t;

    typedef struct {
        logic        pc, ifid, flush, bubble;
        logic [1:0]  fa, fb;
        logic        ba, bb;
        logic [31:0] stall, fcnt;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    typedef struct packed {
        logic [REG_W-1:0] rs, rt, dest;
        logic             rw, mr;
    } slot_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: the three instructions in EX, MEM, WB plus unbounded event counts.
    slot_t pipe[3];
    bit    m_after_flush;
    int    m_stall, m_flush;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic in_t mk(input logic v, input int rs, input int rt, input logic urs,
                               input logic urt, input int dest, input logic rw, input logic mr,
                               input logic jump, input logic br);
        in_t r;
        r.valid = v; r.rs = REG_W'(rs); r.rt = REG_W'(rt); r.urs = urs; r.urt = urt;
        r.dest = REG_W'(dest); r.rw = rw; r.mr = mr; r.jump = jump; r.br = br;
        return r;
    endfunction

    function automatic out_t eo(input logic pc, input logic ifid, input logic fl, input logic bub,
                                input int fa, input int fb, input logic ba, input logic bb,
                                input int stall, input int fcnt);
        out_t r;
        r.pc = pc; r.ifid = ifid; r.flush = fl; r.bubble = bub; r.fa = 2'(fa); r.fb = 2'(fb);
        r.ba = ba; r.bb = bb; r.stall = 32'(stall); r.fcnt = 32'(fcnt);
        return r;
    endfunction

    function automatic in_t rand_in();
        in_t r;
        r.valid = ($urandom_range(0, 9) != 0);
        r.rs    = REG_W'($urandom_range(0, 3));
        r.rt    = REG_W'($urandom_range(0, 3));
        r.urs   = ($urandom_range(0, 3) != 0);
        r.urt   = ($urandom_range(0, 1) != 0);
        r.dest  = REG_W'($urandom_range(0, 3));
        r.rw    = ($urandom_range(0, 9) < 7);
        r.mr    = ($urandom_range(0, 9) < 3);
        r.jump  = ($urandom_range(0, 11) == 0);
        r.br    = ($urandom_range(0, 11) == 0);
        return r;
    endfunction

    task automatic drive(input in_t v);
        id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        id_dest = v.dest; id_reg_write = v.rw; id_mem_read = v.mr; id_jump = v.jump;
        ex_branch_taken = v.br;
    endtask

    function automatic out_t sample_big();
        out_t o;
        o.pc = pc_enable; o.ifid = if_id_enable; o.flush = if_id_flush; o.bubble = id_ex_bubble;
        o.fa = fwd_a_sel; o.fb = fwd_b_sel; o.ba = id_bypass_a; o.bb = id_bypass_b;
        o.stall = 32'(stall_cycles); o.fcnt = 32'(flush_cycles);
        return o;
    endfunction

    function automatic out_t sample_small();
        out_t o;
        o.pc = s_pc_enable; o.ifid = s_if_id_enable; o.flush = s_if_id_flush; o.bubble = s_id_ex_bubble;
        o.fa = s_fwd_a_sel; o.fb = s_fwd_b_sel; o.ba = s_id_bypass_a; o.bb = s_id_bypass_b;
        o.stall = 32'(s_stall_cycles); o.fcnt = 32'(s_flush_cycles);
        return o;
    endfunction

    task automatic check_outputs(input string tag, input out_t a, input out_t e);
        check({tag, ".pc_enable"},    32'(a.pc),     32'(e.pc));
        check({tag, ".if_id_enable"}, 32'(a.ifid),   32'(e.ifid));
        check({tag, ".if_id_flush"},  32'(a.flush),  32'(e.flush));
        check({tag, ".id_ex_bubble"}, 32'(a.bubble), 32'(e.bubble));
        check({tag, ".fwd_a_sel"},    32'(a.fa),     32'(e.fa));
        check({tag, ".fwd_b_sel"},    32'(a.fb),     32'(e.fb));
        check({tag, ".id_bypass_a"},  32'(a.ba),     32'(e.ba));
        check({tag, ".id_bypass_b"},  32'(a.bb),     32'(e.bb));
        check({tag, ".stall_cycles"}, a.stall,       e.stall);
        check({tag, ".flush_cycles"}, a.fcnt,        e.fcnt);
    endtask

    function automatic logic [1:0] model_src(input logic [REG_W-1:0] r);
        if (pipe[1].rw && pipe[1].dest != 0 && pipe[1].dest == r) return 2'd2;
        if (pipe[2].rw && pipe[2].dest != 0 && pipe[2].dest == r) return 2'd1;
        return 2'd0;
    endfunction

    function automatic out_t model_expect(input in_t i, input int cnt_max);
        out_t e;
        bit   hazard;
        hazard = i.valid && pipe[0].mr && pipe[0].rw && pipe[0].dest != 0 &&
                 ((i.urs && i.rs == pipe[0].dest) || (i.urt && i.rt == pipe[0].dest));
        e = eo(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        if (!m_after_flush) begin
            if (i.br)                    begin e.flush = 1; e.bubble = 1; end
            else if (hazard)             begin e.pc = 0; e.ifid = 0; e.bubble = 1; end
            else if (i.jump && i.valid)  e.flush = 1;
        end
        e.fa    = model_src(pipe[0].rs);
        e.fb    = model_src(pipe[0].rt);
        e.ba    = pipe[2].rw && pipe[2].dest != 0 && pipe[2].dest == i.rs;
        e.bb    = pipe[2].rw && pipe[2].dest != 0 && pipe[2].dest == i.rt;
        e.stall = 32'((m_stall > cnt_max) ? cnt_max : m_stall);
        e.fcnt  = 32'((m_flush > cnt_max) ? cnt_max : m_flush);
        return e;
    endfunction

    task automatic model_update(input in_t i, input out_t e);
        slot_t nx;
        nx = '0;
        if (!e.bubble && i.valid) begin
            nx.rs = i.rs; nx.rt = i.rt; nx.dest = i.dest; nx.rw = i.rw; nx.mr = i.mr;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nx;
        m_after_flush = e.flush && e.bubble;
        if (!e.pc)   m_stall++;
        if (e.flush) m_flush++;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        m_after_flush = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  nop, lw8, add8, jmp, ri;
        out_t idle, e;
        vec_t v;

        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw8  = mk(1, 1, 8, 1, 0, 8, 1, 1, 0, 0);
        add8 = mk(1, 8, 10, 1, 1, 9, 1, 0, 0, 0);
        jmp  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle = eo(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Directed table: {inputs, expected outputs before the edge}, starting from reset.
        v.i = lw8;                              v.o = eo(1,1,0,0, 0,0, 0,0, 0,0); vq.push_back(v);
        v.i = add8;                             v.o = eo(0,0,0,1, 0,0, 0,0, 0,0); vq.push_back(v);
        v.i = add8;                             v.o = eo(1,1,0,0, 0,0, 0,0, 1,0); vq.push_back(v);
        v.i = nop;                              v.o = eo(1,1,0,0, 1,0, 0,0, 1,0); vq.push_back(v);
        v.i = mk(1,1,2,1,1,8,1,0,0,0);          v.o = eo(1,1,0,0, 0,0, 0,0, 1,0); vq.push_back(v);
        v.i = mk(1,8,8,1,1,9,1,0,0,0);          v.o = eo(1,1,0,0, 0,0, 0,0, 1,0); vq.push_back(v);
        v.i = nop;                              v.o = eo(1,1,0,0, 2,2, 0,0, 1,0); vq.push_back(v);
        v.i = mk(1,8,3,1,1,4,0,0,0,0);          v.o = eo(1,1,0,0, 0,0, 1,0, 1,0); vq.push_back(v);
        v.i = mk(1,1,0,1,0,0,1,1,0,0);          v.o = eo(1,1,0,0, 0,0, 0,0, 1,0); vq.push_back(v);
        v.i = mk(1,0,0,1,1,5,1,0,0,0);          v.o = eo(1,1,0,0, 0,0, 0,0, 1,0); vq.push_back(v);
        v.i = nop;                              v.o = eo(1,1,0,0, 0,0, 0,0, 1,0); vq.push_back(v);
        v.i = mk(1,0,0,1,1,0,0,0,0,0);          v.o = eo(1,1,0,0, 0,0, 0,0, 1,0); vq.push_back(v);
        v.i = mk(1,1,7,1,0,7,1,1,0,0);          v.o = eo(1,1,0,0, 0,0, 0,0, 1,0); vq.push_back(v);
        v.i = mk(1,7,0,1,0,0,0,0,1,1);          v.o = eo(1,1,1,1, 0,0, 0,0, 1,0); vq.push_back(v);
        v.i = mk(1,7,0,1,0,0,0,0,1,0);          v.o = eo(1,1,0,0, 0,0, 0,0, 1,1); vq.push_back(v);
        v.i = nop;                              v.o = eo(1,1,0,0, 1,0, 0,0, 1,1); vq.push_back(v);
        v.i = jmp;                              v.o = eo(1,1,1,0, 0,0, 0,0, 1,1); vq.push_back(v);
        v.i = nop;                              v.o = eo(1,1,0,0, 0,0, 0,0, 1,2); vq.push_back(v);

        // Reset held low with random inputs: outputs stay at their reset values.
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(rand_in());
            @(negedge clk);
            check_outputs($sformatf("rst%0d", c), sample_big(), idle);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        drive(nop);
        @(negedge clk);
        check_outputs("rst_rel", sample_big(), idle);
        @(posedge clk);
        #1;

        do_reset();
        foreach (vq[n]) begin
            drive(vq[n].i);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", n), sample_big(), vq[n].o);
            @(posedge clk);
            #1;
        end

        // Randomized run against the reference model, both counter widths.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ri = rand_in();
            drive(ri);
            @(negedge clk);
            e = model_expect(ri, (1 << CNT_W) - 1);
            check_outputs($sformatf("rnd%0d", c), sample_big(), e);
            check_outputs($sformatf("rnd_s%0d", c), sample_small(), model_expect(ri, (1 << SMALL_W) - 1));
            @(posedge clk);
            model_update(ri, e);
            #1;
        end

        // Counter saturation: 20 load-use stalls and 20 jump flushes.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(lw8);  @(posedge clk); #1;
            drive(add8); @(posedge clk); #1;
            drive(nop);  @(posedge clk); #1;
        end
        check("sat.stall_big",   32'(stall_cycles),   32'd20);
        check("sat.stall_small", 32'(s_stall_cycles), 32'd15);
        check("sat.flush_big",   32'(flush_cycles),   32'd0);
        for (int k = 0; k < 20; k++) begin
            drive(jmp); @(posedge clk); #1;
        end
        check("sat.flush_big",    32'(flush_cycles),   32'd20);
        check("sat.flush_small",  32'(s_flush_cycles), 32'd15);
        check("sat.stall_hold",   32'(s_stall_cycles), 32'd15);

        // Reset asserted during the stall cycle aborts it at once.
        do_reset();
        drive(lw8); @(posedge clk); #1;
        drive(add8); #1;
        check("abort.pre_pc", 32'(pc_enable), 32'd0);
        reset = 1'b0; #1;
        check("abort.pc",     32'(pc_enable),    32'd1);
        check("abort.bubble", 32'(id_ex_bubble), 32'd0);
        check("abort.ifid",   32'(if_id_enable), 32'd1);
        @(posedge clk); #1 reset = 1'b1;

        // Reset asserted while in LSTALL: the following cycle runs normally.
        do_reset();
        drive(lw8);  @(posedge clk); #1;
        drive(add8); @(posedge clk); #1;
        check("lst.stall", 32'(stall_cycles), 32'd1);
        reset = 1'b0; #1;
        check("lst.rst_pc",    32'(pc_enable),    32'd1);
        check("lst.rst_stall", 32'(stall_cycles), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        drive(jmp);
        @(negedge clk);
        check("lst.run_pc",    32'(pc_enable),   32'd1);
        check("lst.run_flush", 32'(if_id_flush), 32'd1);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
